// File: rtl/sram_1r1w_pkg.sv
// rtl/sram_1r1w_pkg.sv - shared types and byte-lane merge helper for sram_1r1w
package sram_1r1w_pkg;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } sram_state_e;

    // Byte-lane merge: picks the incoming byte where its enable is set.
    // The write path and the read-new bypass both use it, so they cannot disagree.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - optional extra read-data stage for sram_1r1w
module sram_rd_pipe
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // With RD_LATENCY=1 the stage is held idle and bypassed; synthesis prunes it.
    localparam logic EXTRA_STAGE = (RD_LATENCY == 2);

    logic                  stg_valid;
    logic [DATA_WIDTH-1:0] stg_data;

    // Extra stage: data only loads on a valid read so rdata_o holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
        end else begin
            stg_valid <= valid_i & EXTRA_STAGE;
            if (valid_i && EXTRA_STAGE) begin
                stg_data <= data_i;
            end
        end
    end

    assign rvalid_o = EXTRA_STAGE ? stg_valid : valid_i;
    assign rdata_o  = EXTRA_STAGE ? stg_data  : data_i;

endmodule

// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - 1R1W SRAM with byte enables, hardware clear and selectable read latency
module sram_1r1w
    import sram_1r1w_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
    parameter int                    RD_LATENCY = 1,
    parameter rdw_mode_e             RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   wbe_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  init_done_o
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
        $error("sram_1r1w: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0 || BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
        $error("sram_1r1w: DATA_WIDTH must be a multiple of 8 with one enable per byte");
    end

    // One extra address bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state;
    sram_state_e           state_nxt;
    logic                  run;
    logic [ADDR_WIDTH-1:0] init_cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  collision;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  arr_valid;
    logic [DATA_WIDTH-1:0] arr_data;

    // State register: reset always restarts the clear sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave init after the last location has been cleared
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_cnt == LAST_ADDR) begin
            state_nxt = S_RUN;
        end
    end

    // State outputs: ports are live only in S_RUN
    always_comb begin
        run = 1'b0;
        case (state)
            S_INIT:  run = 1'b0;
            S_RUN:   run = 1'b1;
            default: run = 1'b0;
        endcase
        init_done_o = run;
    end

    // Init counter: walks 0..DEPTH-1 once per reset, then parks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == S_INIT && init_cnt != LAST_ADDR) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign wr_in_range = ({1'b0, waddr_i} < DEPTH_W);
    assign rd_in_range = ({1'b0, raddr_i} < DEPTH_W);
    assign wr_old      = wr_in_range ? mem[waddr_i] : '0;
    assign collision   = run && we_i && re_i && (raddr_i == waddr_i);

    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_merge
        assign wr_merged[8*b +: 8] = be_merge(wr_old[8*b +: 8], wdata_i[8*b +: 8], wbe_i[b]);
    end

    // Write mux: init clear owns the array until run, then the write port
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wr_merged;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = INIT_VALUE;
        end else begin
            mem_we = we_i && wr_in_range && (|wbe_i);
        end
    end

    // Storage array: no reset, contents come from the init sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_fire = run && re_i;

    // Read word select: out-of-range reads return zero, collisions honour RDW_MODE
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE == RDW_NEW && collision) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[raddr_i];
            end
        end
    end

    // Array output register: first read stage, data held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_valid <= 1'b0;
            arr_data  <= '0;
        end else begin
            arr_valid <= rd_fire;
            if (rd_fire) begin
                arr_data <= rd_word;
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (arr_valid),
        .data_i   (arr_data),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

endmodule

// File: tb/tb_sram_1r1w.sv
// tb/tb_sram_1r1w.sv - scoreboard bench for three sram_1r1w configurations
module tb_sram_1r1w;
    import sram_1r1w_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re = 1'b0;
    logic [3:0]  raddr = '0;

    logic [31:0] rd [3];
    logic        rv [3];
    logic        done [3];

    exp_t        q [3][$];
    int          lat [3] = '{1, 2, 1};
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: depth 16, latency 1, old-data; u1: depth 16, latency 2, new-data; u2: depth 12
    sram_1r1w u0 (
        .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
        .re_i(re), .raddr_i(raddr), .rdata_o(rd[0]), .rvalid_o(rv[0]), .init_done_o(done[0])
    );
    sram_1r1w #(.RD_LATENCY(2), .RDW_MODE(RDW_NEW)) u1 (
        .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
        .re_i(re), .raddr_i(raddr), .rdata_o(rd[1]), .rvalid_o(rv[1]), .init_done_o(done[1])
    );
    sram_1r1w #(.DEPTH(12)) u2 (
        .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
        .re_i(re), .raddr_i(raddr), .rdata_o(rd[2]), .rvalid_o(rv[2]), .init_done_o(done[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic issue(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic r, input logic [3:0] ra,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [2:0] want);
        exp_t e;
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; wbe = be; re = r; raddr = ra;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                if (want[i]) begin
                    e.data = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
                    e.due  = cyc + lat[i];
                    q[i].push_back(e);
                end
            end
        end
    endtask

    task automatic rd_all(input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2);
        issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, ra, e0, e1, e2, 3'b111);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            we = 1'b0; re = 1'b0; wbe = 4'h0;
        end
    endtask

    task automatic init_sweep();
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check($sformatf("init_done_u0_k%0d", k), {31'b0, done[0]}, {31'b0, k >= 16});
            check($sformatf("init_done_u1_k%0d", k), {31'b0, done[1]}, {31'b0, k >= 16});
            check($sformatf("init_done_u2_k%0d", k), {31'b0, done[2]}, {31'b0, k >= 12});
            if (k == 10) re = 1'b0;
        end
    endtask

    // Monitor: pops one expectation per strobe, checks data and arrival cycle
    always begin
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            while (q[i].size() > 0 && q[i][0].due < cyc) begin
                total++;
                $display("FAIL missed_read u%0d: no strobe by cycle %0d, expected %h", i, cyc, q[i][0].data);
                void'(q[i].pop_front());
            end
            if (rv[i]) begin
                total++;
                if (q[i].size() == 0) begin
                    $display("FAIL unexpected_rvalid u%0d: cycle %0d data %h, expected no strobe", i, cyc, rd[i]);
                end else begin
                    e = q[i].pop_front();
                    if (rd[i] === e.data && cyc == e.due) passed++;
                    else $display("FAIL read_u%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                  i, rd[i], cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rdata_u%0d", i), rd[i], 32'h0);
            check($sformatf("reset_rvalid_u%0d", i), {31'b0, rv[i]}, 32'h0);
            check($sformatf("reset_done_u%0d", i), {31'b0, done[i]}, 32'h0);
        end
        rst_n = 1'b1;
        re = 1'b1; raddr = 4'd2;
        init_sweep();

        for (int a = 0; a < 16; a++) rd_all(4'(a), 32'h0, 32'h0, 32'h0);
        idle(3);

        issue(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 0, 0, 0, 3'b000);
        rd_all(4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(3);

        issue(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0, 0, 0, 0, 3'b000);
        issue(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0, 0, 0, 0, 3'b000);
        rd_all(4'd5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

        issue(1'b1, 4'd7, 32'h00000055, 4'hF, 1'b1, 4'd7, 32'h0, 32'h55, 32'h0, 3'b111);
        rd_all(4'd7, 32'h55, 32'h55, 32'h55);

        issue(1'b1, 4'd9, 32'h99999999, 4'h0, 1'b0, 4'd0, 0, 0, 0, 3'b000);
        rd_all(4'd9, 32'h0, 32'h0, 32'h0);

        issue(1'b1, 4'd13, 32'h000000FF, 4'hF, 1'b0, 4'd0, 0, 0, 0, 3'b000);
        rd_all(4'd13, 32'hFF, 32'hFF, 32'h0);
        for (int a = 0; a < 12; a++) begin
            logic [31:0] v;
            v = (a == 3) ? 32'hDEADBEEF : (a == 5) ? 32'h11BB33DD : (a == 7) ? 32'h55 : 32'h0;
            rd_all(4'(a), v, v, v);
        end
        idle(4);
        for (int i = 0; i < 3; i++) check($sformatf("drain1_u%0d", i), q[i].size(), 0);

        issue(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 3'b101);
        @(negedge clk);
        re = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset_done_u%0d", i), {31'b0, done[i]}, 32'h0);
            check($sformatf("midreset_rvalid_u%0d", i), {31'b0, rv[i]}, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_sweep();
        rd_all(4'd3, 32'h0, 32'h0, 32'h0);
        rd_all(4'd13, 32'h0, 32'h0, 32'h0);
        idle(4);
        for (int i = 0; i < 3; i++) check($sformatf("drain2_u%0d", i), q[i].size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
